// File: rtl/adns_motion_accum.sv
// ADNS-3080 motion-burst accumulator.
// Captures the seven-byte motion burst: Motion, Delta_X, Delta_Y, SQUAL,
// Shutter_Upper, Shutter_Lower and Maximum_Pixel.
// Qualified frames are folded into saturating signed X/Y accumulators.
// The block publishes a valid flag, a surface-quality byte, a frame counter
// and a discard pulse.
module adns_motion_accum #(
    parameter int          ACC_W     = 16,
    parameter logic [7:0]  SQUAL_MIN = 8'd16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Burst_Start,
    input  logic [7:0]       Rx_Dat,
    input  logic             Rx_Dat_Rdy,
    input  logic             Clr_Acc,
    input  logic             Out_Rd_Req,
    output logic [ACC_W-1:0] Dx_Acc,
    output logic [ACC_W-1:0] Dy_Acc,
    output logic [7:0]       Squal,
    output logic [7:0]       Sample_Cnt,
    output logic             Frame_Vld,
    output logic             Frame_Err
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        B_MOT  = 4'd1,
        B_DX   = 4'd2,
        B_DY   = 4'd3,
        B_SQ   = 4'd4,
        B_SHU  = 4'd5,
        B_SHL  = 4'd6,
        B_MAX  = 4'd7,
        COMMIT = 4'd8
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t     state_r;

    // One register per burst byte, in arrival order
    logic [7:0] mot_r;
    logic [7:0] dx_r;
    logic [7:0] dy_r;
    logic [7:0] sq_r;
    logic [7:0] shu_r;
    logic [7:0] shl_r;
    logic [7:0] max_r;

    logic             commit_s;
    logic             ovf_s;
    logic             mot_s;
    logic             qual_ok_s;
    logic             abort_s;
    logic [ACC_W-1:0] dx_sum_s;
    logic [ACC_W-1:0] dy_sum_s;
    logic [7:0]       cnt_inc_s;

    // Shutter, max-pixel and the spare Motion bits are captured for
    // completeness but do not steer accumulation.
    logic             unused_bytes_s;

    // Add a sign-extended 8-bit delta to the accumulator, clamping at the
    // two's-complement limits instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] acc,
        input logic [7:0]       delta
    );
        logic [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc} + {{(ACC_W-7){delta[7]}}, delta};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            if (sum[ACC_W]) begin
                sat_add = ACC_MIN;
            end else begin
                sat_add = ACC_MAX;
            end
        end else begin
            sat_add = sum[ACC_W-1:0];
        end
    endfunction

    // Frame qualification and the saturated candidate values for this commit
    always_comb begin
        commit_s  = (state_r == COMMIT);
        ovf_s     = mot_r[4];
        mot_s     = mot_r[7];
        qual_ok_s = (sq_r >= SQUAL_MIN);
        abort_s   = state_r inside {B_DX, B_DY, B_SQ, B_SHU, B_SHL, B_MAX};
        dx_sum_s  = sat_add(Dx_Acc, dx_r);
        dy_sum_s  = sat_add(Dy_Acc, dy_r);
        if (Sample_Cnt == 8'hFF) begin
            cnt_inc_s = 8'hFF;
        end else begin
            cnt_inc_s = Sample_Cnt + 8'd1;
        end
    end

    assign unused_bytes_s = ^{shu_r, shl_r, max_r, mot_r[6:5], mot_r[3:0]};

    // Burst sequencer: captures one byte per strobe. Burst_Start always
    // restarts the sequence; a restart mid-frame reports the lost frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            mot_r   <= 8'd0;
            dx_r    <= 8'd0;
            dy_r    <= 8'd0;
            sq_r    <= 8'd0;
            shu_r   <= 8'd0;
            shl_r   <= 8'd0;
            max_r   <= 8'd0;
        end else if (Burst_Start) begin
            state_r <= B_MOT;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                B_MOT: begin
                    if (Rx_Dat_Rdy) begin
                        mot_r   <= Rx_Dat;
                        state_r <= B_DX;
                    end
                end
                B_DX: begin
                    if (Rx_Dat_Rdy) begin
                        dx_r    <= Rx_Dat;
                        state_r <= B_DY;
                    end
                end
                B_DY: begin
                    if (Rx_Dat_Rdy) begin
                        dy_r    <= Rx_Dat;
                        state_r <= B_SQ;
                    end
                end
                B_SQ: begin
                    if (Rx_Dat_Rdy) begin
                        sq_r    <= Rx_Dat;
                        state_r <= B_SHU;
                    end
                end
                B_SHU: begin
                    if (Rx_Dat_Rdy) begin
                        shu_r   <= Rx_Dat;
                        state_r <= B_SHL;
                    end
                end
                B_SHL: begin
                    if (Rx_Dat_Rdy) begin
                        shl_r   <= Rx_Dat;
                        state_r <= B_MAX;
                    end
                end
                B_MAX: begin
                    if (Rx_Dat_Rdy) begin
                        max_r   <= Rx_Dat;
                        state_r <= COMMIT;
                    end
                end
                COMMIT: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Result registers. The consumer acknowledge is applied first so that a
    // same-cycle commit re-sets Frame_Vld. Clr_Acc is applied last so that it
    // overrides the accumulation of a coinciding commit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Dx_Acc     <= '0;
            Dy_Acc     <= '0;
            Squal      <= 8'd0;
            Sample_Cnt <= 8'd0;
            Frame_Vld  <= 1'b0;
            Frame_Err  <= 1'b0;
        end else begin
            Frame_Err <= Burst_Start & abort_s;

            if (Out_Rd_Req) begin
                Frame_Vld <= 1'b0;
            end

            if (commit_s) begin
                if (ovf_s) begin
                    Frame_Err <= 1'b1;
                end else begin
                    Squal     <= sq_r;
                    Frame_Vld <= 1'b1;
                    if (qual_ok_s && mot_s) begin
                        Dx_Acc     <= dx_sum_s;
                        Dy_Acc     <= dy_sum_s;
                        Sample_Cnt <= cnt_inc_s;
                    end
                end
            end

            if (Clr_Acc) begin
                Dx_Acc     <= '0;
                Dy_Acc     <= '0;
                Sample_Cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_adns_motion_accum.sv
// Directed bench for adns_motion_accum: hand-computed expectations for
// nominal, saturation, discard, abort, clear and reset scenarios.
module tb_adns_motion_accum;

    logic        CLK;
    logic        RST;
    logic        Burst_Start;
    logic [7:0]  Rx_Dat;
    logic        Rx_Dat_Rdy;
    logic        Clr_Acc;
    logic        Out_Rd_Req;
    logic [15:0] Dx_Acc;
    logic [15:0] Dy_Acc;
    logic [7:0]  Squal;
    logic [7:0]  Sample_Cnt;
    logic        Frame_Vld;
    logic        Frame_Err;

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;
    int e0;
    logic [15:0] pre_dx;
    logic        pre_vld;

    adns_motion_accum #(.ACC_W(16), .SQUAL_MIN(8'd16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Burst_Start(Burst_Start),
        .Rx_Dat     (Rx_Dat),
        .Rx_Dat_Rdy (Rx_Dat_Rdy),
        .Clr_Acc    (Clr_Acc),
        .Out_Rd_Req (Out_Rd_Req),
        .Dx_Acc     (Dx_Acc),
        .Dy_Acc     (Dy_Acc),
        .Squal      (Squal),
        .Sample_Cnt (Sample_Cnt),
        .Frame_Vld  (Frame_Vld),
        .Frame_Err  (Frame_Err)
    );

    // 100 MHz clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Count Frame_Err pulses, sampled away from the active edge
    always @(negedge CLK) begin
        if (Frame_Err === 1'b1) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one strobe and returns at the next negedge
    task automatic send_byte(input logic [7:0] b);
        Rx_Dat     = b;
        Rx_Dat_Rdy = 1'b1;
        @(negedge CLK);
        Rx_Dat_Rdy = 1'b0;
        Rx_Dat     = 8'h00;
    endtask

    task automatic burst_pulse();
        Burst_Start = 1'b1;
        @(negedge CLK);
        Burst_Start = 1'b0;
    endtask

    // Full burst; optional Clr_Acc / Out_Rd_Req during the COMMIT cycle.
    // Returns once results are visible.
    task automatic send_frame(input logic [7:0] mot, input logic [7:0] dx,
                              input logic [7:0] dy, input logic [7:0] sq,
                              input bit clr_c, input bit rd_c);
        burst_pulse();
        send_byte(mot);
        send_byte(dx);
        send_byte(dy);
        send_byte(sq);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h7F);
        pre_dx     = Dx_Acc;
        pre_vld    = Frame_Vld;
        Clr_Acc    = clr_c;
        Out_Rd_Req = rd_c;
        @(negedge CLK);
        Clr_Acc    = 1'b0;
        Out_Rd_Req = 1'b0;
    endtask

    task automatic read_ack();
        Out_Rd_Req = 1'b1;
        @(negedge CLK);
        Out_Rd_Req = 1'b0;
    endtask

    initial begin
        RST         = 1'b1;
        Burst_Start = 1'b0;
        Rx_Dat      = 8'h00;
        Rx_Dat_Rdy  = 1'b0;
        Clr_Acc     = 1'b0;
        Out_Rd_Req  = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_dx", Dx_Acc, 16'h0000);
        check("rst_dy", Dy_Acc, 16'h0000);
        check("rst_squal", Squal, 8'h00);
        check("rst_cnt", Sample_Cnt, 8'h00);
        check("rst_vld", Frame_Vld, 1'b0);
        check("rst_err", Frame_Err, 1'b0);
        RST = 1'b0;
        @(negedge CLK);

        // Strobes before any Burst_Start are ignored
        send_byte(8'h80); send_byte(8'h05); send_byte(8'hFD); send_byte(8'h20);
        send_byte(8'h00); send_byte(8'h40); send_byte(8'h7F);
        repeat (2) @(negedge CLK);
        check("stray_vld", Frame_Vld, 1'b0);
        check("stray_dx", Dx_Acc, 16'h0000);

        // Nominal frame, with latency check at the COMMIT cycle
        send_frame(8'h80, 8'h05, 8'hFD, 8'h20, 1'b0, 1'b0);
        check("nom_pre_vld", pre_vld, 1'b0);
        check("nom_pre_dx", pre_dx, 16'h0000);
        check("nom_dx", Dx_Acc, 16'h0005);
        check("nom_dy", Dy_Acc, 16'hFFFD);
        check("nom_squal", Squal, 8'h20);
        check("nom_cnt", Sample_Cnt, 8'h01);
        check("nom_vld", Frame_Vld, 1'b1);

        read_ack();
        check("ack_vld", Frame_Vld, 1'b0);

        // Overflow frame is discarded
        e0 = err_pulses;
        send_frame(8'h90, 8'h10, 8'h10, 8'h33, 1'b0, 1'b0);
        @(negedge CLK);
        check("ovf_err", err_pulses - e0, 1);
        check("ovf_dx", Dx_Acc, 16'h0005);
        check("ovf_dy", Dy_Acc, 16'hFFFD);
        check("ovf_squal", Squal, 8'h20);
        check("ovf_cnt", Sample_Cnt, 8'h01);
        check("ovf_vld", Frame_Vld, 1'b0);

        // Low quality: Squal and Frame_Vld only
        send_frame(8'h80, 8'h10, 8'h10, 8'h0F, 1'b0, 1'b0);
        check("lq_squal", Squal, 8'h0F);
        check("lq_vld", Frame_Vld, 1'b1);
        check("lq_dx", Dx_Acc, 16'h0005);
        check("lq_dy", Dy_Acc, 16'hFFFD);
        check("lq_cnt", Sample_Cnt, 8'h01);

        // MOT clear: Squal only
        send_frame(8'h00, 8'h10, 8'h10, 8'h30, 1'b0, 1'b0);
        check("nomot_squal", Squal, 8'h30);
        check("nomot_dx", Dx_Acc, 16'h0005);
        check("nomot_cnt", Sample_Cnt, 8'h01);

        // Burst_Start while in B_MOT restarts silently
        e0 = err_pulses;
        burst_pulse();
        send_frame(8'h80, 8'h01, 8'h02, 8'h20, 1'b0, 1'b0);
        check("silent_err", err_pulses - e0, 0);
        check("silent_dx", Dx_Acc, 16'h0006);
        check("silent_dy", Dy_Acc, 16'hFFFF);
        check("silent_cnt", Sample_Cnt, 8'h02);

        // Abort after three bytes, then a complete frame
        e0 = err_pulses;
        burst_pulse();
        send_byte(8'h80); send_byte(8'h01); send_byte(8'h01);
        send_frame(8'h80, 8'h01, 8'h01, 8'h21, 1'b0, 1'b0);
        check("abort_err", err_pulses - e0, 1);
        check("abort_dx", Dx_Acc, 16'h0007);
        check("abort_dy", Dy_Acc, 16'h0000);
        check("abort_squal", Squal, 8'h21);
        check("abort_cnt", Sample_Cnt, 8'h03);

        // Standalone clear
        Clr_Acc = 1'b1;
        @(negedge CLK);
        Clr_Acc = 1'b0;
        check("clr_dx", Dx_Acc, 16'h0000);
        check("clr_dy", Dy_Acc, 16'h0000);
        check("clr_cnt", Sample_Cnt, 8'h00);
        check("clr_squal", Squal, 8'h21);

        // Saturation: 257 frames of +127/-127, counter pins at FF
        for (int i = 0; i < 257; i++) begin
            send_frame(8'h80, 8'h7F, 8'h81, 8'h20, 1'b0, 1'b0);
        end
        check("sat_cnt", Sample_Cnt, 8'hFF);
        check("pre_dx", Dx_Acc, 16'h7F7F);
        check("pre_dy", Dy_Acc, 16'h8081);
        send_frame(8'h80, 8'h71, 8'h84, 8'h20, 1'b0, 1'b0);
        check("load_dx", Dx_Acc, 16'h7FF0);
        check("load_dy", Dy_Acc, 16'h8005);
        send_frame(8'h80, 8'h7F, 8'h80, 8'h20, 1'b0, 1'b0);
        check("sat_dx_max", Dx_Acc, 16'h7FFF);
        check("sat_dy_min", Dy_Acc, 16'h8000);
        check("sat_cnt_hold", Sample_Cnt, 8'hFF);
        send_frame(8'h80, 8'h80, 8'h7F, 8'h20, 1'b0, 1'b0);
        check("unsat_dx", Dx_Acc, 16'h7F7F);
        check("unsat_dy", Dy_Acc, 16'h807F);

        // Clr_Acc in the COMMIT cycle wins over accumulation
        read_ack();
        send_frame(8'h80, 8'h05, 8'h05, 8'h25, 1'b1, 1'b0);
        check("cc_dx", Dx_Acc, 16'h0000);
        check("cc_dy", Dy_Acc, 16'h0000);
        check("cc_cnt", Sample_Cnt, 8'h00);
        check("cc_squal", Squal, 8'h25);
        check("cc_vld", Frame_Vld, 1'b1);

        // Out_Rd_Req in the COMMIT cycle: set wins
        send_frame(8'h80, 8'h05, 8'h05, 8'h26, 1'b0, 1'b1);
        check("rc_vld", Frame_Vld, 1'b1);
        check("rc_dx", Dx_Acc, 16'h0005);
        check("rc_cnt", Sample_Cnt, 8'h01);

        // Reset during B_DY
        e0 = err_pulses;
        burst_pulse();
        send_byte(8'h80); send_byte(8'h05);
        RST = 1'b1;
        @(negedge CLK);
        check("mrst_dx", Dx_Acc, 16'h0000);
        check("mrst_dy", Dy_Acc, 16'h0000);
        check("mrst_squal", Squal, 8'h00);
        check("mrst_cnt", Sample_Cnt, 8'h00);
        check("mrst_vld", Frame_Vld, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        send_byte(8'hFD); send_byte(8'h20); send_byte(8'h00);
        send_byte(8'h40); send_byte(8'h7F);
        repeat (2) @(negedge CLK);
        check("mrst_err", err_pulses - e0, 0);
        check("mrst_post_vld", Frame_Vld, 1'b0);
        check("mrst_post_squal", Squal, 8'h00);
        check("mrst_post_dx", Dx_Acc, 16'h0000);

        send_frame(8'h80, 8'h03, 8'h03, 8'h22, 1'b0, 1'b0);
        check("new_dx", Dx_Acc, 16'h0003);
        check("new_dy", Dy_Acc, 16'h0003);
        check("new_squal", Squal, 8'h22);
        check("new_cnt", Sample_Cnt, 8'h01);
        check("new_vld", Frame_Vld, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
